mux_scan_n: RTL

Registered, parametrised N-channel, W-bit multiplexer with two selection modes. In manual mode, a loaded select register picks the channel. In scan mode, an internal sequencer steps through the channels enabled in a mask, dwelling a programmable number of cycles on each. It generalises the team's 8:1 single-bit combinational mux into a clocked channel selector, used to time-share one display or measurement path across several sources.

---
 rtl/mux_scan_n.sv | 103 ++++++++++
 1 files changed

// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit selector: manual channel select or masked round-robin
// scan with a fixed dwell per channel, plus wrap and bad-select pulses.
module mux_scan_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*WIDTH-1:0]  data_in,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       load,
  input  logic                       mode,
  input  logic [CHANNELS-1:0]        ch_mask,
  output logic [WIDTH-1:0]           y,
  output logic [SEL_W-1:0]           y_ch,
  output logic                       y_valid,
  output logic                       wrap,
  output logic                       sel_err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  logic [SEL_W-1:0] r_curSel;
  logic [CNT_W-1:0] r_dwellCnt;
  logic             r_modeQ;
  logic [WIDTH-1:0] r_y;
  logic [SEL_W-1:0] r_yCh;
  logic             r_yValid;
  logic             r_wrap;
  logic             r_selErr;

  logic [WIDTH-1:0] w_chData [CHANNELS];
  logic [SEL_W-1:0] w_target;
  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign w_chData[g] = data_in[g*WIDTH +: WIDTH];
  end

  // Circular search from cur_sel+1; cur_sel itself is the last candidate.
  always_comb begin
    w_target = r_curSel;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_idx = SEL_W'((int'(r_curSel) + k) % CHANNELS);
      if (!w_found && ch_mask[w_idx]) begin
        w_found  = 1'b1;
        w_target = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_curSel   <= '0;
      r_dwellCnt <= '0;
      r_modeQ    <= 1'b0;
      r_y        <= '0;
      r_yCh      <= '0;
      r_yValid   <= 1'b0;
      r_wrap     <= 1'b0;
      r_selErr   <= 1'b0;
    end else begin
      r_modeQ  <= mode;
      r_wrap   <= 1'b0;
      r_selErr <= 1'b0;
      r_y      <= w_chData[r_curSel];
      r_yCh    <= r_curSel;
      r_yValid <= mode ? ch_mask[r_curSel] : 1'b1;
      // A mode change restarts the dwell so a fresh scan holds the current channel fully.
      if (mode != r_modeQ) begin
        r_dwellCnt <= '0;
      end else if (!mode) begin
        r_dwellCnt <= '0;
        if (load) begin
          if ({1'b0, sel} < CH_LIM) r_curSel <= sel;
          else                      r_selErr <= 1'b1;
        end
      end else if (!w_found) begin
        r_dwellCnt <= '0;
      end else if (r_dwellCnt == LAST_CNT) begin
        r_dwellCnt <= '0;
        r_curSel   <= w_target;
        r_wrap     <= (w_target <= r_curSel);
      end else begin
        r_dwellCnt <= r_dwellCnt + CNT_W'(1);
      end
    end
  end

  assign y       = r_y;
  assign y_ch    = r_yCh;
  assign y_valid = r_yValid;
  assign wrap    = r_wrap;
  assign sel_err = r_selErr;

endmodule
